// File: rtl/uart_score_reporter_pkg.sv
// Shared types and constants for the UART score reporter: FSM states, event
// codes, ASCII bytes of the 6-byte frame and the event-letter lookup.
package uart_score_reporter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_ACK   = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [1:0] EVT_SCORE = 2'b00;
   localparam logic [1:0] EVT_BEGIN = 2'b01;
   localparam logic [1:0] EVT_END   = 2'b10;
   localparam logic [1:0] EVT_RSVD  = 2'b11;

   localparam logic [7:0] ASC_S     = 8'h53;
   localparam logic [7:0] ASC_B     = 8'h42;
   localparam logic [7:0] ASC_E     = 8'h45;
   localparam logic [7:0] ASC_COLON = 8'h3A;
   localparam logic [7:0] ASC_ZERO  = 8'h30;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;

   localparam int FRAME_LEN = 6;

   // Reserved codes never reach a frame, so they share the score letter.
   function automatic logic [7:0] event_letter(input logic [1:0] evt);
      case (evt)
         EVT_BEGIN: return ASC_B;
         EVT_END:   return ASC_E;
         default:   return ASC_S;
      endcase
   endfunction

endpackage

// File: rtl/uart_score_reporter_ascii.sv
// Combinational score formatter: clamps to 99 and emits the tens and ones
// digits as ASCII. Shared with the seven-segment path.
module score_to_ascii2
   import uart_score_reporter_pkg::*;
#(
   parameter int W = 7
) (
   input  logic [W-1:0] value,
   output logic [7:0]   tens_ascii,
   output logic [7:0]   ones_ascii
);

   logic [7:0] value_ext;
   logic [6:0] clamped;
   logic [3:0] tens;
   logic [6:0] tens_x10;
   logic [6:0] ones;

   assign value_ext = 8'(value);
   assign clamped   = (value_ext > 8'd99) ? 7'd99 : value_ext[6:0];

   // Compare-subtract: the largest multiple of ten not above the value wins.
   always_comb begin
      tens     = 4'd0;
      tens_x10 = 7'd0;
      for (int i = 1; i <= 9; i++) begin
         if (clamped >= 7'(i * 10)) begin
            tens     = 4'(i);
            tens_x10 = 7'(i * 10);
         end
      end
   end

   assign ones       = clamped - tens_x10;
   assign tens_ascii = ASC_ZERO + {4'd0, tens};
   assign ones_ascii = ASC_ZERO + {1'b0, ones};

endmodule

// File: rtl/uart_score_reporter.sv
// Sequences uart_tx so each game event goes out as "<L>:<tens><ones>\r\n",
// one byte per busy handshake, with a single newest-wins pending slot.
module uart_score_reporter
   import uart_score_reporter_pkg::*;
#(
   parameter int SCORE_W     = 6,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               report_req,
   input  logic [1:0]         event_type,
   input  logic [SCORE_W-1:0] score,
   input  logic               uart_tx_busy,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   output logic               reporter_busy,
   output logic               overrun,
   output logic               ack_error
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   state_t             state_reg;
   logic [2:0]         idx_reg;
   logic [1:0]         act_evt_reg;
   logic [SCORE_W-1:0] act_score_reg;
   logic               pend_valid_reg;
   logic [1:0]         pend_evt_reg;
   logic [SCORE_W-1:0] pend_score_reg;
   logic [CNT_W-1:0]   cnt_reg;

   logic       req_valid;
   logic [7:0] tens_ascii;
   logic [7:0] ones_ascii;
   logic [7:0] frame_byte;

   assign req_valid = report_req && (event_type != EVT_RSVD);

   // Overwriting a held report is flagged in the very cycle it happens.
   assign overrun = req_valid && (state_reg != ST_IDLE) && pend_valid_reg;

   score_to_ascii2 #(.W(SCORE_W)) u_digits (
      .value      (act_score_reg),
      .tens_ascii (tens_ascii),
      .ones_ascii (ones_ascii)
   );

   always_comb begin
      frame_byte = ASC_LF;
      case (idx_reg)
         3'd0:    frame_byte = event_letter(act_evt_reg);
         3'd1:    frame_byte = ASC_COLON;
         3'd2:    frame_byte = tens_ascii;
         3'd3:    frame_byte = ones_ascii;
         3'd4:    frame_byte = ASC_CR;
         default: frame_byte = ASC_LF;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         idx_reg        <= 3'd0;
         act_evt_reg    <= EVT_SCORE;
         act_score_reg  <= '0;
         pend_valid_reg <= 1'b0;
         pend_evt_reg   <= EVT_SCORE;
         pend_score_reg <= '0;
         cnt_reg        <= '0;
         tx_start       <= 1'b0;
         tx_data        <= 8'h00;
         reporter_busy  <= 1'b0;
         ack_error      <= 1'b0;
      end else begin
         tx_start <= 1'b0;

         // Any mid-frame request lands in the pending slot; DONE may consume it below.
         if (req_valid && state_reg != ST_IDLE) begin
            pend_valid_reg <= 1'b1;
            pend_evt_reg   <= event_type;
            pend_score_reg <= score;
         end

         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  act_evt_reg   <= event_type;
                  act_score_reg <= score;
                  idx_reg       <= 3'd0;
                  reporter_busy <= 1'b1;
                  state_reg     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               tx_data   <= frame_byte;
               tx_start  <= 1'b1;
               state_reg <= ST_START;
            end
            ST_START: begin
               cnt_reg   <= CNT_W'(1);
               state_reg <= ST_ACK;
            end
            ST_ACK: begin
               if (uart_tx_busy) begin
                  state_reg <= ST_DRAIN;
               end else if (cnt_reg >= CNT_W'(ACK_TIMEOUT - 1)) begin
                  ack_error <= 1'b1;
                  state_reg <= ST_DRAIN;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            ST_DRAIN: begin
               if (!uart_tx_busy) begin
                  if (idx_reg == 3'(FRAME_LEN - 1)) begin
                     state_reg <= ST_DONE;
                  end else begin
                     idx_reg   <= idx_reg + 3'd1;
                     state_reg <= ST_LOAD;
                  end
               end
            end
            ST_DONE: begin
               if (req_valid) begin
                  act_evt_reg    <= event_type;
                  act_score_reg  <= score;
                  pend_valid_reg <= 1'b0;
                  idx_reg        <= 3'd0;
                  state_reg      <= ST_LOAD;
               end else if (pend_valid_reg) begin
                  act_evt_reg    <= pend_evt_reg;
                  act_score_reg  <= pend_score_reg;
                  pend_valid_reg <= 1'b0;
                  idx_reg        <= 3'd0;
                  state_reg      <= ST_LOAD;
               end else begin
                  reporter_busy <= 1'b0;
                  state_reg     <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_score_reporter.sv
// Bench for uart_score_reporter: a frame-level timeline model predicts every
// tx_start, byte, busy, overrun and ack_error cycle; directed cases pin it down.
module tb_uart_score_reporter;

   localparam int SW = 7;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          report_req = 1'b0;
   logic [1:0]    event_type = 2'b00;
   logic [SW-1:0] score = '0;
   logic          uart_tx_busy = 1'b0;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          reporter_busy;
   logic          overrun;
   logic          ack_error;

   always #5 clock = ~clock;

   uart_score_reporter #(.SCORE_W(SW), .ACK_TIMEOUT(15)) dut (
      .clock         (clock),
      .reset         (reset),
      .report_req    (report_req),
      .event_type    (event_type),
      .score         (score),
      .uart_tx_busy  (uart_tx_busy),
      .tx_start      (tx_start),
      .tx_data       (tx_data),
      .reporter_busy (reporter_busy),
      .overrun       (overrun),
      .ack_error     (ack_error)
   );

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } exp_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   hold    = 20;   // uart model: busy cycles per byte
   bit   to_mode = 1'b0; // uart model never raises busy
   int   last_start = 0;
   bit   have_start = 1'b0;

   exp_t exp_q[$];
   int   m_done = -10;
   int   m_busy_from = 0;
   int   m_ack_at = -1;
   bit   m_pv = 1'b0;
   int   m_pe = 0;
   int   m_ps = 0;

   logic [7:0] log_q[$];
   int   start_q[$];
   int   ovr_cnt = 0;
   int   ack_rise = -1;
   bit   prev_ack = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int evt, input int sc, input int k);
      int v;
      v = (sc > 99) ? 99 : sc;
      case (k)
         0:       return (evt == 1) ? 8'h42 : ((evt == 2) ? 8'h45 : 8'h53);
         1:       return 8'h3A;
         2:       return 8'(8'h30 + v / 10);
         3:       return 8'(8'h30 + v % 10);
         4:       return 8'h0D;
         default: return 8'h0A;
      endcase
   endfunction

   // A frame whose first start is at s0 emits one byte every P cycles;
   // its DONE cycle is one period after the last start, minus one.
   task automatic schedule(input int s0, input int evt, input int sc);
      int   p;
      exp_t e;
      p = to_mode ? 17 : hold + 3;
      for (int k = 0; k < 6; k++) begin
         e.cyc  = s0 + k * p;
         e.data = exp_byte(evt, sc, k);
         exp_q.push_back(e);
      end
      m_done = s0 + 6 * p - 1;
      if (to_mode && m_ack_at < 0) m_ack_at = s0 + 15;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_done     = -10;
      m_pv       = 1'b0;
      m_ack_at   = -1;
      have_start = 1'b0;
      prev_ack   = 1'b0;
   endtask

   task automatic clear_log();
      log_q.delete();
      start_q.delete();
      ovr_cnt  = 0;
      ack_rise = -1;
   endtask

   task automatic tick(input bit req, input int evt, input int sc);
      bit         s_start, s_rb, s_ack, s_ovr, valid, exp_start, exp_ovr;
      logic [7:0] s_data;
      exp_t       e;
      @(negedge clock);
      cyc++;
      s_start = tx_start;
      s_data  = tx_data;
      s_rb    = reporter_busy;
      s_ack   = ack_error;
      uart_tx_busy = !to_mode && have_start && (cyc >= last_start + 1) && (cyc <= last_start + hold);
      if (s_start) begin
         last_start = cyc;
         have_start = 1'b1;
         log_q.push_back(s_data);
         start_q.push_back(cyc);
         $display("[TB] cycle %0d tx_start byte %02h", cyc, s_data);
      end
      if (s_ack && !prev_ack) ack_rise = cyc;
      prev_ack   = s_ack;
      report_req = req;
      event_type = 2'(evt);
      score      = SW'(sc);
      #1;
      s_ovr = overrun;
      if (s_ovr) ovr_cnt++;

      valid   = req && (evt != 3);
      exp_ovr = 1'b0;
      if (valid) begin
         if (cyc > m_done) begin
            schedule(cyc + 2, evt, sc);
            m_busy_from = cyc + 1;
         end else begin
            exp_ovr = m_pv;
            m_pv = 1'b1;
            m_pe = evt;
            m_ps = sc;
         end
      end
      if (cyc == m_done && m_pv) begin
         schedule(cyc + 2, m_pe, m_ps);
         m_pv = 1'b0;
      end

      exp_start = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("tx_start", int'(s_start), int'(exp_start));
      if (exp_start) begin
         e = exp_q.pop_front();
         if (s_start) check("tx_data", int'(s_data), int'(e.data));
      end
      check("reporter_busy", int'(s_rb), int'(cyc >= m_busy_from && cyc <= m_done));
      check("overrun", int'(s_ovr), int'(exp_ovr));
      check("ack_error", int'(s_ack), int'(m_ack_at >= 0 && cyc >= m_ack_at));
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 0, 0);
   endtask

   task automatic run_to_idle();
      int guard = 0;
      while (cyc <= m_done + 2 && guard < 3000) begin
         tick(1'b0, 0, 0);
         guard++;
      end
      check("drain_bound", int'(guard < 3000), 1);
   endtask

   task automatic wait_starts(input int n);
      int guard = 0;
      while (log_q.size() < n && guard < 1000) begin
         tick(1'b0, 0, 0);
         guard++;
      end
      check("start_bound", int'(guard < 1000), 1);
   endtask

   task automatic check_frame(input string name, input int base, input logic [47:0] f);
      if (log_q.size() < base + 6) begin
         check(name, log_q.size(), base + 6);
      end else begin
         for (int k = 0; k < 6; k++)
            check(name, int'(log_q[base + k]), int'(f[47 - 8 * k -: 8]));
      end
   endtask

   task automatic do_reset();
      #2;
      report_req = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_tx_start", int'(tx_start), 0);
      check("rst_reporter_busy", int'(reporter_busy), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_ack_error", int'(ack_error), 0);
      check("rst_tx_data", int'(tx_data), 0);
      model_reset();
      repeat (3) tick(1'b0, 0, 0);
      reset = 1'b0;
   endtask

   initial begin
      int req_c;
      do_reset();
      idle(2);

      // 1: single score frame "S:42"
      clear_log();
      hold = 20;
      tick(1'b1, 0, 42);
      req_c = cyc;
      run_to_idle();
      check_frame("t1_frame", 0, 48'h533A34320D0A);
      check("t1_pulses", start_q.size(), 6);
      if (start_q.size() > 0) check("t1_latency", start_q[0] - req_c, 2);
      check("t1_busy_after", int'(reporter_busy), 0);

      // 2: pending request served back-to-back
      clear_log();
      tick(1'b1, 1, 0);
      wait_starts(3);
      tick(1'b1, 2, 63);
      run_to_idle();
      check_frame("t2_frame_a", 0, 48'h423A30300D0A);
      check_frame("t2_frame_b", 6, 48'h453A36330D0A);
      check("t2_overrun", ovr_cnt, 0);
      if (start_q.size() >= 7) check("t2_gap", start_q[6] - start_q[5], 24);

      // 3: newest pending wins, two overruns
      clear_log();
      tick(1'b1, 0, 30);
      wait_starts(2);
      tick(1'b1, 0, 5);
      idle(3);
      tick(1'b1, 0, 6);
      idle(2);
      tick(1'b1, 0, 7);
      run_to_idle();
      check("t3_overrun", ovr_cnt, 2);
      check("t3_bytes", log_q.size(), 12);
      check_frame("t3_frame_b", 6, 48'h533A30370D0A);

      // 4: clamp to 99, reserved event ignored
      clear_log();
      tick(1'b1, 0, 120);
      idle(4);
      tick(1'b1, 3, 50);
      run_to_idle();
      tick(1'b1, 3, 9);
      idle(5);
      check("t4_bytes", log_q.size(), 6);
      check_frame("t4_frame", 0, 48'h533A39390D0A);
      check("t4_overrun", ovr_cnt, 0);

      // 5: uart never acknowledges
      clear_log();
      to_mode = 1'b1;
      tick(1'b1, 1, 7);
      run_to_idle();
      check("t5_bytes", log_q.size(), 6);
      check_frame("t5_frame", 0, 48'h423A30370D0A);
      if (start_q.size() > 0) check("t5_ack_delay", ack_rise - start_q[0], 15);
      idle(5);
      check("t5_ack_sticky", int'(ack_error), 1);
      do_reset();
      to_mode = 1'b0;
      idle(2);

      // 6: reset mid-frame with a pending report
      clear_log();
      tick(1'b1, 0, 11);
      wait_starts(4);
      tick(1'b1, 2, 22);
      idle(2);
      do_reset();
      idle(60);
      check("t6_no_bytes", log_q.size(), 4);
      clear_log();
      tick(1'b1, 1, 33);
      run_to_idle();
      check_frame("t6_fresh", 0, 48'h423A33330D0A);

      // Randomized traffic against the timeline model
      for (int b = 0; b < 4; b++) begin
         hold = int'($urandom_range(1, 6));
         for (int i = 0; i < 200; i++)
            tick($urandom_range(0, 99) < 6, int'($urandom_range(0, 3)), int'($urandom_range(0, 127)));
         run_to_idle();
      end
      check("final_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_score_reporter.md
Name: uart_score_reporter

Overview:
Sequences the shared UART transmitter so game events reach the host as fixed 6-byte ASCII frames: event letter, ':', two decimal score digits, CR, LF. Sits between game_fsm/score_counter and uart_tx, and owns the tx_start/tx_data interface. Issues one byte per uart_tx handshake and holds one pending report while a frame is in flight.

Parameters:
SCORE_W, 6, width of the score input; legal range 1..7; values above 99 are clamped to "99".
ACK_TIMEOUT, 15, clock cycles allowed after tx_start for uart_tx_busy to rise before ack_error is flagged.

Ports:
clock  input  1  100MHz system clock
reset  input  1  asynchronous, active-high reset
report_req  input  1  one-cycle request pulse
event_type  input  2  2'b00 score update 'S', 2'b01 game begin 'B', 2'b10 game end 'E', 2'b11 reserved
score  input  SCORE_W  current score, sampled when the request is accepted
uart_tx_busy  input  1  busy flag from uart_tx
tx_start  output  1  one-cycle start strobe to uart_tx
tx_data  output  8  byte to uart_tx, stable from the tx_start cycle until busy falls
reporter_busy  output  1  high while a frame is being sent (LOAD through DONE)
overrun  output  1  one-cycle pulse when a pending report is overwritten
ack_error  output  1  sticky; set on busy-rise timeout and cleared only by reset

Behaviour:
- Reset, asynchronous and active-high: state IDLE; tx_start 0; tx_data 8'h00; reporter_busy 0; overrun 0; ack_error 0; pending invalid; byte index 0. A reset in mid-frame aborts the frame with no further bytes and drops any pending report.
- Snapshot: on acceptance the block registers event_type and score, clamped to 99. The digits are computed from the snapshot, so later score changes do not alter the frame.
- Frame bytes, index 0..5: letter ('S' 8'h53, 'B' 8'h42, 'E' 8'h45), ':' 8'h3A, tens digit 8'h30+tens, ones digit 8'h30+ones, 8'h0D, 8'h0A. A score of 0 sends "00", with a leading zero.
- event_type 2'b11 is ignored. It is never accepted, never pended and never raises overrun.
- FSM states: IDLE, LOAD, START, ACK, DRAIN, DONE.
  - IDLE: a valid report_req moves to LOAD on the next cycle, with the snapshot taken in the request cycle.
  - LOAD: drive tx_data for the current index, then go to START.
  - START: tx_start=1 for exactly one cycle, then go to ACK.
  - ACK: wait for uart_tx_busy=1, then go to DRAIN. If ACK_TIMEOUT cycles pass without busy, set ack_error and treat the byte as sent (go to DRAIN).
  - DRAIN: wait for uart_tx_busy=0. Then, if index=5, go to DONE; otherwise increment the index and go to LOAD.
  - DONE: one cycle. If pending is valid, promote it to active, clear pending and go to LOAD with index 0. Otherwise go to IDLE.
- Byte latency: request to first tx_start is 2 cycles (request cycle, then LOAD, then START).
- Pending buffer: one entry. A valid request in any non-IDLE state is stored in pending. If pending is already valid, the new request overwrites it (newest wins) and overrun pulses in that same cycle.
- A request in the DONE cycle goes to pending and is served immediately by that DONE transition. The newer request wins, and overrun fires if an older pending entry was replaced.
- tx_data holds its last value in IDLE.
- reporter_busy is low only in IDLE.

Decomposition:
- Shared package/header holds:
  - state encodings (3-bit);
  - event codes EVT_SCORE, EVT_BEGIN, EVT_END, EVT_RSVD;
  - ASCII constants ASC_S, ASC_B, ASC_E, ASC_COLON, ASC_ZERO, ASC_CR, ASC_LF;
  - FRAME_LEN = 6.
- Sub-module score_to_ascii2: combinational clamp to 99, tens/ones split by compare-subtract, and output of two ASCII bytes. It is reusable for the seven-segment path.

Test Plan:
1. Reset, then report_req with type 00 and score 42, using a uart_tx model that raises busy 1 cycle after start and holds it for 20 cycles -> bytes 53 3A 34 32 0D 0A in order; exactly 6 tx_start pulses; first pulse 2 cycles after the request; reporter_busy falls after DONE.
2. Type 01 with score 0, then type 10 with score 63 issued during byte 2 of the first frame -> frame 42 3A 30 30 0D 0A, then frame 45 3A 36 33 0D 0A back-to-back; no overrun.
3. Three type-00 requests during one frame with scores 5, 6, 7 -> overrun pulses twice; the second frame carries "07" (bytes 53 3A 30 37 0D 0A); the frames for 5 and 6 are never sent.
4. SCORE_W=7 with score 120, then event_type 11 -> the first frame sends "99"; the reserved request produces no tx_start and no overrun.
5. uart_tx model that never raises busy -> ack_error rises 15 cycles after the first tx_start and stays high; all 6 bytes are still issued; ack_error clears only on reset.
6. Assert reset during byte 3 with a pending report held -> tx_start, reporter_busy and overrun go to 0 at once; after release there are no further bytes; a new request sends a complete fresh frame.
